dcache_line_mover: RTL and testbench

//  Initiator side of the DCache memory port: turns one line-granular command (refill or writeback) from the

---
 rtl/dcache_line_mover_pkg.sv | 18 +
 rtl/dcache_line_mover_if.sv | 57 +++++
 rtl/dcache_line_mover.sv | 136 +++++++++++++
 tb/tb_dcache_line_mover.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_line_mover_pkg.sv
// Shared DCache memory-port definitions: machine width, memory operation codes and the
// line-operation record the DCache controller hands to the line mover.
package dcache_line_mover_pkg;

    localparam int XLEN           = 64;
    localparam int DEF_LINE_WORDS = 8;

    typedef enum logic {
        memory_read  = 1'b0,
        memory_write = 1'b1
    } mem_op_e;

    typedef struct packed {
        mem_op_e          op_type;
        logic [XLEN-1:0]  address;
    } line_op_t;

endpackage

// File: rtl/dcache_line_mover_if.sv
// Bundle of the three channels around the line mover: line command in, line done out,
// and the word-granular req/resp memory channel.
interface dcache_line_mover_if
    import dcache_line_mover_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS
);

    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_type;
    logic [XLEN-1:0]            cmd_address;
    logic [LINE_WORDS*XLEN-1:0] cmd_line;

    logic                       done_valid;
    logic                       done_ready;
    logic                       done_type;
    logic [XLEN-1:0]            done_address;
    logic [LINE_WORDS*XLEN-1:0] done_line;
    logic                       done_error;

    logic                       mem_req_type;
    logic [XLEN-1:0]            mem_req_address;
    logic [XLEN-1:0]            mem_req_data;
    logic [1:0]                 mem_req_length;
    logic                       mem_req_valid;
    logic                       mem_req_ready;
    logic [XLEN-1:0]            mem_resp_address;
    logic [XLEN-1:0]            mem_resp_data;
    logic                       mem_resp_valid;
    logic                       mem_resp_ready;

    // master: the line mover itself
    modport master (
        input  cmd_valid, cmd_type, cmd_address, cmd_line,
        output cmd_ready,
        output done_valid, done_type, done_address, done_line, done_error,
        input  done_ready,
        output mem_req_type, mem_req_address, mem_req_data, mem_req_length, mem_req_valid,
        input  mem_req_ready,
        input  mem_resp_address, mem_resp_data, mem_resp_valid,
        output mem_resp_ready
    );

    // slave: controller plus memory responder facing the mover
    modport slave (
        output cmd_valid, cmd_type, cmd_address, cmd_line,
        input  cmd_ready,
        input  done_valid, done_type, done_address, done_line, done_error,
        output done_ready,
        input  mem_req_type, mem_req_address, mem_req_data, mem_req_length, mem_req_valid,
        output mem_req_ready,
        output mem_resp_address, mem_resp_data, mem_resp_valid,
        input  mem_resp_ready
    );

endinterface

// File: rtl/dcache_line_mover.sv
// Turns one line refill/writeback command into LINE_WORDS sequential word requests,
// one outstanding at a time, and reports the assembled line on the done channel.
//
//   state | meaning
//   IDLE  | waiting for a line command (cmd_ready high)
//   REQ   | presenting word idx request on the memory channel
//   RESP  | waiting for the response to word idx
//   DONE  | holding the finished line until the consumer takes it
module dcache_line_mover
    import dcache_line_mover_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int WORD_LEN   = 3
) (
    input  logic                clk,
    input  logic                reset,
    dcache_line_mover_if.master bus
);

    localparam int WORD_BYTES = XLEN / 8;
    localparam int IDX_W      = $clog2(LINE_WORDS);
    localparam int WORD_SHIFT = $clog2(WORD_BYTES);
    localparam logic [XLEN-1:0] OFS_MASK = XLEN'(LINE_WORDS * WORD_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } state_t;

    state_t                           state_q;
    state_t                           state_d;
    logic [IDX_W-1:0]                 idx_q;
    line_op_t                         op_q;
    logic [LINE_WORDS-1:0][XLEN-1:0]  line_q;
    logic                             err_q;

    logic             cmd_fire;
    logic             resp_fire;
    logic             last_word;
    logic [XLEN-1:0]  req_address;

    assign cmd_fire    = (state_q == IDLE) && bus.cmd_valid;
    assign resp_fire   = (state_q == RESP) && bus.mem_resp_valid;
    assign last_word   = (idx_q == IDX_W'(LINE_WORDS - 1));
    // wraps modulo 2^XLEN like the rest of the address path
    assign req_address = op_q.address + (XLEN'(idx_q) << WORD_SHIFT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        bus.cmd_ready      = 1'b0;
        bus.mem_req_valid  = 1'b0;
        bus.mem_resp_ready = 1'b0;
        bus.done_valid     = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.mem_resp_ready = 1'b1;
                if (bus.mem_resp_valid) begin
                    state_d = last_word ? DONE : REQ;
                end
            end
            DONE: begin
                bus.done_valid = 1'b1;
                if (bus.done_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Refill words land in the same buffer that holds writeback data, so done_line
    // needs no mux between the two operation types.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= '0;
            op_q   <= '0;
            line_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (cmd_fire) begin
                op_q.op_type <= mem_op_e'(bus.cmd_type);
                op_q.address <= bus.cmd_address & ~OFS_MASK;
                line_q       <= bus.cmd_line;
                idx_q        <= '0;
                err_q        <= 1'b0;
            end
            if (resp_fire) begin
                if (op_q.op_type == memory_read) begin
                    line_q[idx_q] <= bus.mem_resp_data;
                end
                if (bus.mem_resp_address != req_address) begin
                    err_q <= 1'b1;
                end
                if (!last_word) begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
        end
    end

    // Request fields derive only from registers, so they hold steady through any stall.
    assign bus.mem_req_type    = op_q.op_type;
    assign bus.mem_req_address = req_address;
    assign bus.mem_req_data    = (op_q.op_type == memory_write) ? line_q[idx_q] : '0;
    assign bus.mem_req_length  = 2'(WORD_LEN);

    assign bus.done_type    = op_q.op_type;
    assign bus.done_address = op_q.address;
    assign bus.done_line    = line_q;
    assign bus.done_error   = err_q;

endmodule

// File: tb/tb_dcache_line_mover.sv
// Bench for dcache_line_mover: table of line commands, hand sequences for stall, reset and
// back-to-back corners, then random commands against a line-level reference model.
module tb_dcache_line_mover;
    import dcache_line_mover_pkg::*;

    localparam int LW       = 8;
    localparam int RESP_LAT = 5;
    localparam int NV       = 7;

    typedef logic [XLEN-1:0]    word_t;
    typedef logic [LW*XLEN-1:0] line_t;

    typedef struct {
        logic       typ;
        word_t      addr;
        word_t      data;
        logic [1:0] len;
    } req_t;

    typedef struct {
        logic  typ;
        word_t addr;
        word_t seed;
        int    stall_w;
        int    stall_len;
        int    bad_w;
        int    hold;
        word_t exp_addr;
        logic  exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    int unsigned cyc = 0;
    bit          rst_edge = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= reset;
    end

    dcache_line_mover_if #(.LINE_WORDS(LW)) bus ();

    dcache_line_mover #(
        .LINE_WORDS(LW),
        .WORD_LEN  (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // responder memory (written by DUT requests) and reference memory (written by the model)
    word_t mem [word_t];
    word_t ref_mem [word_t];

    function automatic word_t dflt(input word_t a);
        return {a[31:0] ^ 32'h3C3C_3C3C, a[31:0]};
    endfunction

    function automatic word_t mem_rd(input word_t a);
        if (mem.exists(a)) return mem[a];
        return dflt(a);
    endfunction

    function automatic word_t ref_rd(input word_t a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    req_t  req_log[$];
    req_t  exp_q[$];
    line_t exp_line;
    logic  exp_typ;

    word_t       cfg_base;
    int          cfg_stall_word = -1;
    int          cfg_stall_len  = 0;
    int          stall_left     = 0;
    int          cfg_bad_word   = -1;
    int unsigned resp_edge_pred = 0;

    // memory responder: fixed response latency, optional request stall and address corruption
    initial begin : responder
        bit    pend;
        bit    req_fire;
        bit    resp_fire;
        int    cnt;
        word_t pend_addr;
        word_t pend_data;
        req_t  pr;
        req_t  snap;
        req_t  cur;
        pend      = 1'b0;
        req_fire  = 1'b0;
        resp_fire = 1'b0;
        cnt       = 0;
        pend_addr = '0;
        pend_data = '0;
        bus.mem_req_ready    = 1'b0;
        bus.mem_resp_valid   = 1'b0;
        bus.mem_resp_address = '0;
        bus.mem_resp_data    = '0;
        forever begin
            @(negedge clk);
            if (rst_edge) begin
                pend               = 1'b0;
                bus.mem_resp_valid = 1'b0;
            end else begin
                if (resp_fire) begin
                    pend               = 1'b0;
                    bus.mem_resp_valid = 1'b0;
                end
                if (req_fire) begin
                    chk("one_in_flight", pend, 1'b0);
                    req_log.push_back(pr);
                    if (pr.typ == memory_write) mem[pr.addr] = pr.data;
                    pend      = 1'b1;
                    cnt       = RESP_LAT - 1;
                    pend_addr = pr.addr;
                    pend_data = mem_rd(pr.addr);
                end
            end
            if (pend && !bus.mem_resp_valid) begin
                if (cnt == 0) begin
                    bus.mem_resp_valid   = 1'b1;
                    bus.mem_resp_data    = pend_data;
                    bus.mem_resp_address = (cfg_bad_word >= 0 &&
                        pend_addr == cfg_base + word_t'(8 * cfg_bad_word)) ? 64'hDEAD : pend_addr;
                end else begin
                    cnt--;
                end
            end
            bus.mem_req_ready = 1'b1;
            if (bus.mem_req_valid && stall_left > 0 && cfg_stall_word >= 0 &&
                bus.mem_req_address == cfg_base + word_t'(8 * cfg_stall_word)) begin
                bus.mem_req_ready = 1'b0;
                cur = '{bus.mem_req_type, bus.mem_req_address, bus.mem_req_data, bus.mem_req_length};
                if (stall_left == cfg_stall_len) snap = cur;
                else chk("stall_hold", {cur.typ, cur.addr, cur.data, cur.len},
                         {snap.typ, snap.addr, snap.data, snap.len});
                stall_left--;
            end
            req_fire = bus.mem_req_valid && bus.mem_req_ready;
            if (req_fire) pr = '{bus.mem_req_type, bus.mem_req_address, bus.mem_req_data, bus.mem_req_length};
            resp_fire = bus.mem_resp_valid && bus.mem_resp_ready;
            if (resp_fire) resp_edge_pred = cyc + 1;
        end
    end

    // Builds the expected request stream and line, then presents the command (call at a negedge).
    task automatic start_op(input logic typ, input word_t addr, input word_t seed, input int stall_w,
                            input int stall_len, input int bad_w, output int waited);
        line_t cl;
        word_t base;
        word_t a;
        word_t w;
        bit    tmo;
        base = addr - (addr % 64);
        exp_q.delete();
        for (int k = 0; k < LW; k++) begin
            w = seed + word_t'(k);
            cl[k*XLEN +: XLEN] = w;
            a = base + word_t'(8 * k);
            if (typ == memory_write) begin
                exp_q.push_back('{typ, a, w, 2'd3});
                ref_mem[a] = w;
                exp_line[k*XLEN +: XLEN] = w;
            end else begin
                exp_q.push_back('{typ, a, 64'h0, 2'd3});
                exp_line[k*XLEN +: XLEN] = ref_rd(a);
            end
        end
        exp_typ        = typ;
        cfg_base       = base;
        cfg_stall_word = stall_w;
        cfg_stall_len  = stall_len;
        stall_left     = stall_len;
        cfg_bad_word   = bad_w;
        req_log.delete();
        bus.cmd_type    = typ;
        bus.cmd_address = addr;
        bus.cmd_line    = cl;
        bus.cmd_valid   = 1'b1;
        tmo    = 1'b1;
        waited = 0;
        for (int i = 0; i < 100; i++) begin
            bit acc;
            acc = bus.cmd_ready;
            @(negedge clk);
            if (acc) begin
                tmo = 1'b0;
                break;
            end
            waited++;
        end
        bus.cmd_valid = 1'b0;
        chk("cmd_accept_timeout", tmo, 1'b0);
        chk("first_req_next_cycle", {bus.mem_req_valid, bus.cmd_ready, bus.mem_req_address},
            {1'b1, 1'b0, base});
    endtask

    task automatic finish_op(input string tag, input word_t exp_addr, input logic exp_err,
                             input int hold, input bit pre_cmd);
        bit tmo;
        tmo = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (bus.done_valid) begin
                tmo = 1'b0;
                break;
            end
            @(negedge clk);
        end
        chk($sformatf("%s_done_timeout", tag), tmo, 1'b0);
        if (tmo) return;
        chk($sformatf("%s_done_latency", tag), cyc, resp_edge_pred);
        chk($sformatf("%s_done_fields", tag), {bus.done_type, bus.done_error, bus.done_address},
            {exp_typ, exp_err, exp_addr});
        chk($sformatf("%s_done_line", tag), bus.done_line, exp_line);
        chk($sformatf("%s_nreq", tag), req_log.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < req_log.size(); k++)
            chk($sformatf("%s_req%0d", tag, k),
                {req_log[k].typ, req_log[k].addr, req_log[k].data, req_log[k].len},
                {exp_q[k].typ, exp_q[k].addr, exp_q[k].data, exp_q[k].len});
        if (pre_cmd) bus.cmd_valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk($sformatf("%s_hold%0d", tag, h),
                {bus.done_valid, bus.cmd_ready, bus.mem_req_valid, bus.done_error, bus.done_address},
                {1'b1, 1'b0, 1'b0, exp_err, exp_addr});
            chk($sformatf("%s_hold_line%0d", tag, h), bus.done_line, exp_line);
        end
        bus.done_ready = 1'b1;
        @(negedge clk);
        bus.done_ready = 1'b0;
        chk($sformatf("%s_release", tag), {bus.done_valid, bus.cmd_ready}, 2'b01);
    endtask

    task automatic run_random(input int n);
        logic  t;
        word_t a;
        word_t s;
        int    sw;
        int    sl;
        int    bw;
        int    waited;
        for (int r = 0; r < n; r++) begin
            t  = 1'($urandom_range(0, 1));
            a  = 64'h4000 + word_t'($urandom_range(0, 7) * 64 + $urandom_range(0, 63));
            s  = {$urandom, $urandom};
            sw = $urandom_range(0, 11);
            if (sw >= LW) sw = -1;
            sl = $urandom_range(1, 4);
            bw = $urandom_range(0, 15);
            if (bw >= LW) bw = -1;
            start_op(t, a, s, sw, sl, bw, waited);
            finish_op($sformatf("rnd%0d", r), a - (a % 64), bw >= 0, 0, 1'b0);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs[NV];
        int   waited;
        reset           = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_type    = 1'b0;
        bus.cmd_address = '0;
        bus.cmd_line    = '0;
        bus.done_ready  = 1'b0;

        vecs[0] = '{memory_read,  64'h1008, 64'h0,         -1,  0, -1, 0, 64'h1000, 1'b0};
        vecs[1] = '{memory_write, 64'h2000, 64'hA5A5_0000, -1,  0, -1, 0, 64'h2000, 1'b0};
        vecs[2] = '{memory_read,  64'h2010, 64'h0,          3, 10, -1, 0, 64'h2000, 1'b0};
        vecs[3] = '{memory_read,  64'h1030, 64'h0,         -1,  0,  5, 0, 64'h1000, 1'b1};
        vecs[4] = '{memory_write, 64'h3FFF, 64'h7777_0000, -1,  0, -1, 6, 64'h3FC0, 1'b0};
        vecs[5] = '{memory_read,  64'hFFFF_FFFF_FFFF_FFF8, 64'h0, -1, 0, -1, 0,
                    64'hFFFF_FFFF_FFFF_FFC0, 1'b0};
        vecs[6] = '{memory_write, 64'h103F, 64'h1234_5678_0000_0000, -1, 0, 7, 0, 64'h1000, 1'b1};

        for (int k = 0; k < LW; k++) begin
            mem[64'h1000 + word_t'(8 * k)]     = 64'h1000_0000 + word_t'(k);
            ref_mem[64'h1000 + word_t'(8 * k)] = 64'h1000_0000 + word_t'(k);
        end

        repeat (3) @(negedge clk);
        chk("reset_ctrl", {bus.cmd_ready, bus.mem_req_valid, bus.mem_resp_ready, bus.done_valid,
                           bus.done_error, bus.done_type, bus.done_address}, {1'b1, 5'b0, 64'h0});
        chk("reset_line", bus.done_line, '0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {bus.cmd_ready, bus.mem_req_valid}, 2'b10);

        for (int i = 0; i < NV; i++) begin
            start_op(vecs[i].typ, vecs[i].addr, vecs[i].seed, vecs[i].stall_w,
                     vecs[i].stall_len, vecs[i].bad_w, waited);
            finish_op($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_err, vecs[i].hold, 1'b0);
        end

        // back-to-back: next command already waiting while done is held
        start_op(memory_write, 64'h5000, 64'hBEEF_0000, -1, 0, -1, waited);
        finish_op("b2b_first", 64'h5000, 1'b0, 6, 1'b1);
        start_op(memory_read, 64'h5008, 64'h0, -1, 0, -1, waited);
        chk("b2b_accept_immediate", waited, 0);
        finish_op("b2b_second", 64'h5000, 1'b0, 0, 1'b0);

        // reset while word 4 of a refill is outstanding
        start_op(memory_read, 64'h1000, 64'h0, -1, 0, -1, waited);
        for (int i = 0; i < 200; i++) begin
            if (req_log.size() >= 5) break;
            @(negedge clk);
        end
        chk("midreset_reached_word4", req_log.size() >= 5, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_ctrl", {bus.cmd_ready, bus.mem_req_valid, bus.mem_resp_ready, bus.done_valid,
                              bus.done_error, bus.done_address}, {1'b1, 4'b0, 64'h0});
        chk("midreset_line", bus.done_line, '0);
        @(negedge clk);
        start_op(memory_read, 64'h1018, 64'h0, -1, 0, -1, waited);
        finish_op("after_reset", 64'h1000, 1'b0, 0, 1'b0);

        run_random(16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
